// File: rtl/framebuffer_swap_ctrl.sv
// Double-buffered frame buffer bank controller: display reads the front bank, renderer writes the back bank,
// banks swap only on frame_complete after a commit. Optional frame/swap counters via FB_FRAME_COUNT_EN.
module framebuffer_swap_ctrl #(
    parameter int rows     = 8,
    parameter int columns  = 32,
    parameter int segments = 1,
    parameter int bitwidth = 8
) (
    input  logic                                           clk,
    input  logic                                           rst,
    input  logic                                           frame_complete,
    input  logic [$clog2(rows)-1:0]                        row,
    input  logic [$clog2(columns)-1:0]                     column,
    output logic [$clog2(rows)+$clog2(columns):0]          rd_addr,
    input  logic [$clog2(rows)+$clog2(columns)-1:0]        wr_addr_in,
    input  logic [3*bitwidth*segments-1:0]                 wr_data_in,
    input  logic                                           wr_en_in,
    input  logic                                           wr_commit,
    output logic                                           wr_ready,
    output logic [$clog2(rows)+$clog2(columns):0]          mem_wr_addr,
    output logic [3*bitwidth*segments-1:0]                 mem_wr_data,
    output logic                                           mem_wr_en,
    output logic                                           front_bank,
    output logic                                           swap_done,
`ifdef FB_FRAME_COUNT_EN
    output logic [15:0]                                    frame_count,
    output logic [15:0]                                    swap_count,
`endif
    output logic                                           err_drop
);

    localparam int PIX_AW = $clog2(rows) + $clog2(columns);
    localparam int WORD_W = 3 * bitwidth * segments;

    typedef enum logic [1:0] {
        S_WRITE   = 2'd0,
        S_PENDING = 2'd1,
        S_SWAP    = 2'd2
    } state_t;

    state_t              r_state;
    state_t              w_state_nx;
    logic                r_front_bank;
    logic                r_err_drop;
    logic                r_wr_en_p1;
    logic [PIX_AW:0]     r_wr_addr_p1;
    logic [WORD_W-1:0]   r_wr_data_p1;
    logic                w_wr_ready;
    logic                w_swap;
    logic                w_drop;

    always_comb begin
        w_state_nx = r_state;
        w_wr_ready = 1'b0;
        w_swap     = 1'b0;
        case (r_state)
            S_WRITE: begin
                w_wr_ready = 1'b1;
                // A frame_complete arriving with the commit is not enough: the swap waits for the next one.
                if (wr_commit) w_state_nx = S_PENDING;
            end
            S_PENDING: begin
                if (frame_complete) begin
                    w_swap     = 1'b1;
                    w_state_nx = S_SWAP;
                end
            end
            S_SWAP: begin
                w_state_nx = S_WRITE;
            end
            default: begin
                w_state_nx = S_WRITE;
            end
        endcase
    end

    assign w_drop = (wr_en_in | wr_commit) & ~w_wr_ready;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state      <= S_WRITE;
            r_front_bank <= 1'b0;
            r_err_drop   <= 1'b0;
        end else begin
            r_state <= w_state_nx;
            if (w_swap) r_front_bank <= ~r_front_bank;
            if (w_drop) r_err_drop <= 1'b1;
        end
    end

    // Write stage p1: one-cycle registered path into the back bank.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_wr_en_p1   <= 1'b0;
            r_wr_addr_p1 <= '0;
            r_wr_data_p1 <= '0;
        end else begin
            r_wr_en_p1   <= wr_en_in & w_wr_ready;
            r_wr_addr_p1 <= {~r_front_bank, wr_addr_in};
            r_wr_data_p1 <= wr_data_in;
        end
    end

`ifdef FB_FRAME_COUNT_EN
    logic [15:0] r_frame_count;
    logic [15:0] r_swap_count;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_frame_count <= 16'd0;
            r_swap_count  <= 16'd0;
        end else begin
            if (frame_complete) r_frame_count <= r_frame_count + 16'd1;
            if (r_state == S_SWAP) r_swap_count <= r_swap_count + 16'd1;
        end
    end

    assign frame_count = r_frame_count;
    assign swap_count  = r_swap_count;
`endif

    // Read path is purely combinational so the display pipeline timing is untouched.
    assign rd_addr     = {r_front_bank, row, column};
    assign wr_ready    = w_wr_ready;
    assign mem_wr_en   = r_wr_en_p1;
    assign mem_wr_addr = r_wr_addr_p1;
    assign mem_wr_data = r_wr_data_p1;
    assign front_bank  = r_front_bank;
    assign swap_done   = (r_state == S_SWAP);
    assign err_drop    = r_err_drop;

endmodule

// File: tb/tb_framebuffer_swap_ctrl.sv
// Directed bench for framebuffer_swap_ctrl (rows=8, columns=32, bitwidth=8, segments=1).
module tb_framebuffer_swap_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        frame_complete;
    logic [2:0]  row;
    logic [4:0]  column;
    logic [8:0]  rd_addr;
    logic [7:0]  wr_addr_in;
    logic [23:0] wr_data_in;
    logic        wr_en_in;
    logic        wr_commit;
    logic        wr_ready;
    logic [8:0]  mem_wr_addr;
    logic [23:0] mem_wr_data;
    logic        mem_wr_en;
    logic        front_bank;
    logic        swap_done;
    logic        err_drop;
`ifdef FB_FRAME_COUNT_EN
    logic [15:0] frame_count;
    logic [15:0] swap_count;
`endif

    int nvec  = 0;
    int nfail = 0;

    framebuffer_swap_ctrl #(
        .rows(8), .columns(32), .segments(1), .bitwidth(8)
    ) dut (
        .clk(clk),
        .rst(rst),
        .frame_complete(frame_complete),
        .row(row),
        .column(column),
        .rd_addr(rd_addr),
        .wr_addr_in(wr_addr_in),
        .wr_data_in(wr_data_in),
        .wr_en_in(wr_en_in),
        .wr_commit(wr_commit),
        .wr_ready(wr_ready),
        .mem_wr_addr(mem_wr_addr),
        .mem_wr_data(mem_wr_data),
        .mem_wr_en(mem_wr_en),
        .front_bank(front_bank),
        .swap_done(swap_done),
`ifdef FB_FRAME_COUNT_EN
        .frame_count(frame_count),
        .swap_count(swap_count),
`endif
        .err_drop(err_drop)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    initial begin
        rst = 1'b0; frame_complete = 1'b0; row = '0; column = '0;
        wr_addr_in = '0; wr_data_in = '0; wr_en_in = 1'b0; wr_commit = 1'b0;
        tick();
        tick();
        chk("rst_front", {31'd0, front_bank}, 32'd0);
        chk("rst_ready", {31'd0, wr_ready}, 32'd1);
        chk("rst_wen", {31'd0, mem_wr_en}, 32'd0);
        chk("rst_waddr", {23'd0, mem_wr_addr}, 32'd0);
        chk("rst_wdata", {8'd0, mem_wr_data}, 32'd0);
        chk("rst_swap", {31'd0, swap_done}, 32'd0);
        chk("rst_err", {31'd0, err_drop}, 32'd0);

        rst = 1'b1; row = 3'd3; column = 5'd5;
        tick();
        chk("rd_addr_f0", {23'd0, rd_addr}, 32'h065);

        // Write into back bank 1.
        wr_addr_in = 8'h10; wr_data_in = 24'hABCDEF; wr_en_in = 1'b1;
        tick();
        wr_en_in = 1'b0;
        chk("wr_en", {31'd0, mem_wr_en}, 32'd1);
        chk("wr_addr", {23'd0, mem_wr_addr}, 32'h110);
        chk("wr_data", {8'd0, mem_wr_data}, 32'hABCDEF);
        tick();
        chk("wr_en_off", {31'd0, mem_wr_en}, 32'd0);

        // Commit, then frame_complete 20 cycles later.
        wr_commit = 1'b1;
        tick();
        wr_commit = 1'b0;
        chk("pend_ready_0", {31'd0, wr_ready}, 32'd0);
        for (int i = 1; i < 20; i++) begin
            tick();
            chk("pend_ready", {31'd0, wr_ready}, 32'd0);
            chk("pend_swap", {31'd0, swap_done}, 32'd0);
        end
        chk("pend_front", {31'd0, front_bank}, 32'd0);
        frame_complete = 1'b1;
        tick();
        frame_complete = 1'b0;
        chk("swap_front", {31'd0, front_bank}, 32'd1);
        chk("swap_pulse", {31'd0, swap_done}, 32'd1);
        chk("swap_ready", {31'd0, wr_ready}, 32'd0);
        tick();
        chk("post_swap_pulse", {31'd0, swap_done}, 32'd0);
        chk("post_swap_ready", {31'd0, wr_ready}, 32'd1);
        chk("rd_addr_f1", {23'd0, rd_addr}, 32'h165);

        // Writes now land in bank 0.
        wr_addr_in = 8'hAB; wr_data_in = 24'h123456; wr_en_in = 1'b1;
        tick();
        wr_en_in = 1'b0;
        chk("wr_addr_b0", {23'd0, mem_wr_addr}, 32'h0AB);
        chk("wr_en_b0", {31'd0, mem_wr_en}, 32'd1);

        // frame_complete without a commit is ignored.
        frame_complete = 1'b1;
        tick();
        frame_complete = 1'b0;
        chk("idle_fc_front", {31'd0, front_bank}, 32'd1);
        chk("idle_fc_swap", {31'd0, swap_done}, 32'd0);

        // Commit and frame_complete together: swap only on the next one.
        wr_commit = 1'b1; frame_complete = 1'b1;
        tick();
        wr_commit = 1'b0; frame_complete = 1'b0;
        chk("same_front", {31'd0, front_bank}, 32'd1);
        chk("same_swap", {31'd0, swap_done}, 32'd0);
        chk("same_ready", {31'd0, wr_ready}, 32'd0);
        tick();
        chk("same_front2", {31'd0, front_bank}, 32'd1);
        frame_complete = 1'b1;
        tick();
        frame_complete = 1'b0;
        chk("next_fc_front", {31'd0, front_bank}, 32'd0);
        chk("next_fc_swap", {31'd0, swap_done}, 32'd1);
        tick();
        chk("next_fc_ready", {31'd0, wr_ready}, 32'd1);

        // Write while pending is dropped and flagged.
        wr_commit = 1'b1;
        tick();
        wr_commit = 1'b0;
        chk("drop_err_pre", {31'd0, err_drop}, 32'd0);
        wr_addr_in = 8'h22; wr_en_in = 1'b1;
        tick();
        wr_en_in = 1'b0;
        chk("drop_wen", {31'd0, mem_wr_en}, 32'd0);
        chk("drop_err", {31'd0, err_drop}, 32'd1);
        frame_complete = 1'b1;
        tick();
        frame_complete = 1'b0;
        chk("drop_swap_front", {31'd0, front_bank}, 32'd1);
        tick();
        chk("drop_err_held", {31'd0, err_drop}, 32'd1);

        // Reset while pending with front_bank=1.
        wr_commit = 1'b1;
        tick();
        wr_commit = 1'b0;
        chk("rst2_pre_ready", {31'd0, wr_ready}, 32'd0);
        chk("rst2_pre_front", {31'd0, front_bank}, 32'd1);
        rst = 1'b0;
        tick();
        rst = 1'b1;
        chk("rst2_front", {31'd0, front_bank}, 32'd0);
        chk("rst2_ready", {31'd0, wr_ready}, 32'd1);
        chk("rst2_err", {31'd0, err_drop}, 32'd0);
        frame_complete = 1'b1;
        tick();
        frame_complete = 1'b0;
        chk("rst2_commit_lost", {31'd0, front_bank}, 32'd0);

`ifdef FB_FRAME_COUNT_EN
        rst = 1'b0;
        tick();
        rst = 1'b1;
        chk("cnt_rst_frame", {16'd0, frame_count}, 32'd0);
        chk("cnt_rst_swap", {16'd0, swap_count}, 32'd0);
        wr_commit = 1'b1;
        tick();
        wr_commit = 1'b0;
        for (int i = 0; i < 3; i++) begin
            frame_complete = 1'b1;
            tick();
            frame_complete = 1'b0;
            tick();
        end
        chk("cnt_frame", {16'd0, frame_count}, 32'd3);
        chk("cnt_swap", {16'd0, swap_count}, 32'd1);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end

endmodule
